nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 SHALL use one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 a  input  W  operand A.
REQ-006 b  input  W  operand B.
REQ-007 cin  input  1  carry-in to nibble 0.
REQ-008 in_valid  input  1  operands and cin are valid.
REQ-009 in_ready  output  1  block can accept an operation.
REQ-010 sum  output  W  result sum.
REQ-011 cout  output  1  carry out of the top nibble.
REQ-012 out_valid  output  1  sum and cout are valid.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 busy  output  1  high in state ADD.

Function
REQ-015 Nibble arithmetic SHALL be done by one instance of the 4-bit ripple-carry adder rca_4bit (a, b, cin, sum, cout), reused every cycle; no wider adder is allowed.
REQ-016 States:
- IDLE: in_ready=1.
- ADD: busy=1.
- DONE: out_valid=1.
REQ-017 Acceptance SHALL occur on an edge in IDLE with in_valid=1. On that edge: register a, b, cin; clear nibble index to 0; go to ADD.
REQ-018 In ADD, each edge SHALL:
- apply nibble [4i+3:4i] of the registered operands and the carry register to rca_4bit;
- write the rca_4bit sum into sum[4i+3:4i];
- load the carry register with the rca_4bit cout;
- increment i.
REQ-019 On the ADD edge with i = NIBBLES-1, the block SHALL go to DONE and load cout from the final carry.
REQ-020 Latency SHALL be exactly NIBBLES edges from the accepting edge to out_valid=1; for NIBBLES=4 that is 4 cycles.
REQ-021 In DONE, sum, cout and out_valid SHALL hold stable until an edge with out_ready=1. That edge returns the block to IDLE and clears out_valid.
REQ-022 in_valid outside IDLE SHALL be ignored; no operand capture, no state change.
REQ-023 out_ready outside DONE SHALL be ignored.
REQ-024 One operation is in flight at a time; minimum issue interval is NIBBLES+2 cycles.
REQ-025 Results are modulo 2^W with carry in cout: {cout,sum} = a + b + cin exactly.
REQ-026 The index counter SHALL be ceil(log2(NIBBLES)) bits wide, SHALL never wrap inside an operation, and SHALL reset to 0 on leaving ADD.

Reset
REQ-027 On an edge with rst_n=0, in any state including mid-ADD, the block SHALL enter IDLE and clear all of: sum, cout, out_valid, busy, carry register, index, operand registers.
REQ-028 While rst_n=0, in_ready SHALL be 0; it is 1 in the first cycle after reset is released.
REQ-029 An operation interrupted by reset SHALL be discarded with no out_valid pulse.

Configuration
REQ-030 Macro SIGNED_OVF_EN:
- Defined: adds output port ovf (1 bit), meaning two's-complement overflow = carry into the MSB XOR carry out of the MSB. ovf is valid with out_valid, held in DONE, and reset to 0.
- Undefined: no ovf port and no associated logic. All other behaviour is identical.

Verification (NIBBLES=4)
REQ-031 Basic add: a=0x0001, b=0x0001, cin=0, accepted -> 4 cycles later out_valid=1, sum=0x0002, cout=0.
REQ-032 Full carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
REQ-033 Backpressure: a=0x1234, b=0x1111, out_ready held low 3 cycles after out_valid -> sum=0x2345 stable all 3 cycles; a second in_valid pulse during ADD/DONE is not accepted. After out_ready=1, in_ready=1 the next cycle.
REQ-034 Reset mid-operation: rst_n=0 for 1 cycle at the 2nd ADD cycle -> IDLE, sum=0, out_valid never asserts; next operation a=0x000F, b=0x0001 -> sum=0x0010.
REQ-035 Overflow, macro defined: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0; a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1.
REQ-036 Random check: 1000 random a, b, cin compared against {cout,sum} = a+b+cin, plus a scoreboard confirming latency of exactly 4 cycles.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit ripple-carry slice reused over NIBBLES cycles per operation.
// Optional SIGNED_OVF_EN adds a two's-complement overflow output (ovf).

module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic w_carry;

    // Bit-level ripple chain, carry walked through a procedural variable
    always_comb begin
        sum     = 4'b0000;
        w_carry = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule

module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SIGNED_OVF_EN
    output logic                 ovf,
`endif
    output logic                 busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_carry;
    logic [IW-1:0]  r_idx;
    logic [W-1:0]   r_sum;
    logic           r_cout;
    logic           r_out_valid;
    logic           r_busy;
    logic           r_in_ready;

    logic [3:0]     w_nib_a;
    logic [3:0]     w_nib_b;
    logic [3:0]     w_nib_sum;
    logic           w_nib_cout;
    logic           w_last;

    assign w_nib_a = r_a[{r_idx, 2'b00} +: 4];
    assign w_nib_b = r_b[{r_idx, 2'b00} +: 4];
    assign w_last  = (r_idx == IW'(NIBBLES - 1));

    rca_4bit u_rca (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

`ifdef SIGNED_OVF_EN
    logic r_ovf;
    logic w_msb_cin;

    // Carry into the operand MSB recovered from the top slice's sum bit
    assign w_msb_cin = w_nib_a[3] ^ w_nib_b[3] ^ w_nib_sum[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_ADD && w_last) begin
            r_ovf <= w_msb_cin ^ w_nib_cout;
        end
    end

    assign ovf = r_ovf;
`endif

    // Control FSM and datapath registers; in_ready is held low for one cycle after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (r_in_ready && in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_nib_sum;
                    r_carry                    <= w_nib_cout;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_cout      <= w_nib_cout;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4); define SIGNED_OVF_EN to also check ovf.

module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
`ifdef SIGNED_OVF_EN
    logic        ovf;
`endif

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SIGNED_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) timeout_fail("wait_in_ready");
    endtask

    task automatic wait_out_valid(output bit ok);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
        if (!ok) timeout_fail("wait_out_valid");
    endtask

    function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        exp_t        e;
        logic [16:0] full;
        full   = 17'(va) + 17'(vb) + 17'(vc);
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (va[15] == vb[15]) && (full[15] != va[15]);
        e.acc  = 0;
        return e;
    endfunction

    // Present one operation at a negedge; push the expectation after the accepting edge
    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc, input bit push);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (push) begin
            e     = model(va, vb, vc);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    // Monitor: checks latency on out_valid rise and data on each handshake
    initial begin : monitor
        bit   prev_ov = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (q.size() == 0) timeout_fail("unexpected_out_valid");
                    else chk("latency", 32'(cyc - q[0].acc), 32'd4);
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
`ifdef SIGNED_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit ok;
        int n;
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Directed vectors
        issue(16'h0001, 16'h0001, 1'b0, 1'b1);
        chk("busy_in_add", 32'(busy), 32'd1);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        issue(16'h8000, 16'h8000, 1'b0, 1'b1);
        issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);

        // Backpressure with ignored in_valid pulses during ADD and DONE
        wait_ready(ok);
        out_ready = 1'b0;
        issue(16'h1234, 16'h1111, 1'b0, 1'b1);
        a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_in_ready_add", 32'(in_ready), 32'd0);
        chk("bp_busy_add", 32'(busy), 32'd1);
        wait_out_valid(ok);
        for (int h = 0; h < 3; h++) begin
            chk("bp_sum_hold", 32'(sum), 32'h2345);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready_done", 32'(in_ready), 32'd0);
            in_valid = (h == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", 32'(in_ready), 32'd1);
        chk("bp_valid_cleared", 32'(out_valid), 32'd0);

        // Reset during the second ADD cycle discards the operation
        issue(16'h5555, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (8) @(negedge clk);
        chk("midrst_no_valid", 32'(out_valid), 32'd0);
        issue(16'h000F, 16'h0001, 1'b0, 1'b1);

        // Random operations
        for (int i = 0; i < 1000; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) timeout_fail("drain_scoreboard");
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
